// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: loader states and frame geometry.
package prog_loader_pkg;

  // Bytes per 32-bit word, which is also the length of the count header.
  localparam int HDR_BYTES  = 4;
  localparam int BYTE_CNT_W = $clog2(HDR_BYTES);

  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Byte packer: collects four accepted bytes, little-endian, into a 32-bit word.
// Bytes shift in from the top, so byte0 ends up in bits [7:0] once the word
// is complete. word_valid_o is a registered one-cycle flag raised after the
// last byte of a word, but only while the owner enables flagging (data words,
// not the header).
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  input  logic        flagEn_i,
  output logic        wordDone_o,
  output logic [31:0] wordNext_o,
  output logic [31:0] word_o,
  output logic        wordValid_o
);

  logic [BYTE_CNT_W-1:0] byteCnt_q, byteCnt_d;
  logic [31:0]           word_q, word_d;
  logic                  wordValid_q, wordValid_d;
  logic                  lastByte;

  // Next-state for the byte counter, the partial word and the completion flag.
  always_comb begin
    lastByte    = (byteCnt_q == BYTE_CNT_W'(HDR_BYTES - 1));
    byteCnt_d   = byteCnt_q;
    word_d      = word_q;
    wordValid_d = 1'b0;
    wordDone_o  = 1'b0;
    wordNext_o  = {data_i, word_q[31:8]};
    if (clear_i) begin
      byteCnt_d = '0;
      word_d    = '0;
    end else if (accept_i) begin
      byteCnt_d   = byteCnt_q + BYTE_CNT_W'(1);
      word_d      = wordNext_o;
      wordValid_d = lastByte && flagEn_i;
      wordDone_o  = lastByte;
    end
  end

  // Packer registers; without an accepted byte everything holds across gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      byteCnt_q   <= '0;
      word_q      <= '0;
      wordValid_q <= 1'b0;
    end else begin
      byteCnt_q   <= byteCnt_d;
      word_q      <= word_d;
      wordValid_q <= wordValid_d;
    end
  end

  assign word_o      = word_q;
  assign wordValid_o = wordValid_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a byte-stream program image (little-endian word
// count followed by that many little-endian words), writes it into the core's
// instruction memory and releases the core from reset once the image is in.
// mem_we/mem_addr/mem_wdata go to the riscv_core memory write port and
// core_reset to its reset input.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wordIdx_q, wordIdx_d;
  logic [ADDR_W-1:0] lastIdx_q, lastIdx_d;
  logic              accept;
  logic              clear;
  logic              wordDone;
  logic              wordValid;
  logic [31:0]       wordNext;
  logic [31:0]       word;

  assign in_ready = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign accept   = in_valid && in_ready;
  assign clear    = restart && ((state_q == ST_DONE) || (state_q == ST_ERR));

  byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
    .accept_i    (accept),
    .data_i      (in_data),
    .flagEn_i    (state_q == ST_DATA),
    .wordDone_o  (wordDone),
    .wordNext_o  (wordNext),
    .word_o      (word),
    .wordValid_o (wordValid)
  );

  // Next state, header decode and word-index bookkeeping. The final word's
  // 4th byte moves straight to DONE so its write cycle already sees done=1.
  always_comb begin
    state_d   = state_q;
    lastIdx_d = lastIdx_q;
    wordIdx_d = wordIdx_q;
    if (wordValid) begin
      wordIdx_d = wordIdx_q + ADDR_W'(1);
    end
    case (state_q)
      ST_LEN: begin
        if (wordDone) begin
          if (wordNext == 32'd0) begin
            state_d = ST_DONE;
          end else if (wordNext > 32'(MEM_WORDS)) begin
            state_d = ST_ERR;
          end else begin
            state_d   = ST_DATA;
            lastIdx_d = wordNext[ADDR_W-1:0] - ADDR_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (wordDone && (wordIdx_q == lastIdx_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: begin
        if (restart) begin
          state_d   = ST_LEN;
          wordIdx_d = '0;
          lastIdx_d = '0;
        end
      end
      default: state_d = ST_LEN;
    endcase
  end

  // State and index registers; reset wins over restart and byte acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LEN;
      wordIdx_q <= '0;
      lastIdx_q <= '0;
    end else begin
      state_q   <= state_d;
      wordIdx_q <= wordIdx_d;
      lastIdx_q <= lastIdx_d;
    end
  end

  // Status and memory-port outputs decoded from the registered state.
  always_comb begin
    core_reset = (state_q != ST_DONE);
    done       = (state_q == ST_DONE);
    error      = (state_q == ST_ERR);
    mem_we     = wordValid;
    mem_addr   = wordIdx_q;
    mem_wdata  = word;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: a per-cycle vector table followed by hand-written
// sequences for input gaps and a reset that abandons a frame mid-image.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  data;
    logic        rstrt;
    logic        eRdy;
    logic        eWe;
    logic        eCr;
    logic        eDone;
    logic        eErr;
    logic        chkAw;
    logic [9:0]  eAddr;
    logic [31:0] eData;
  } vec_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  writeLog[$];

  prog_loader #(.MEM_WORDS(1024), .ADDR_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) writeLog.push_back('{addr: mem_addr, data: mem_wdata});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addV(input logic rst, input logic vld, input logic [7:0] data, input logic rstrt,
                      input logic eRdy, input logic eWe, input logic eCr, input logic eDone,
                      input logic eErr, input logic chkAw, input logic [9:0] eAddr,
                      input logic [31:0] eData);
    vecs.push_back('{rst: rst, vld: vld, data: data, rstrt: rstrt, eRdy: eRdy, eWe: eWe,
                     eCr: eCr, eDone: eDone, eErr: eErr, chkAw: chkAw, eAddr: eAddr,
                     eData: eData});
  endtask

  // Drive one cycle of inputs, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic [7:0] data,
                               input logic rstrt);
    reset    = rst;
    in_valid = vld;
    in_data  = data;
    restart  = rstrt;
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    applyStimulus(1'b0, 1'b1, b, 1'b0);
    for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulseReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(v.eRdy));
    checkOutput($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(v.eWe));
    checkOutput($sformatf("v%0d.core_reset", i), 32'(core_reset), 32'(v.eCr));
    checkOutput($sformatf("v%0d.done", i), 32'(done), 32'(v.eDone));
    checkOutput($sformatf("v%0d.error", i), 32'(error), 32'(v.eErr));
    if (v.chkAw) begin
      checkOutput($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(v.eAddr));
      checkOutput($sformatf("v%0d.mem_wdata", i), mem_wdata, v.eData);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;

    // Columns: rst vld data rstrt | rdy we cr done err | chkAw addr wdata
    addV(1,0,8'h00,0, 1,0,1,0,0, 1,10'd0,32'h0);
    // Two-word image: header 2, then 0x00A00513 and 0x00100593 back to back.
    addV(0,1,8'h02,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h13,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h05,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'ha0,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,1,1,0,0, 1,10'd0,32'h00A00513);
    addV(0,1,8'h93,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h05,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h10,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 0,1,0,1,0, 1,10'd1,32'h00100593);
    // Done: offered bytes are refused and the core stays running.
    addV(0,1,8'hff,0, 0,0,0,1,0, 0,10'd0,32'h0);
    addV(0,1,8'h13,0, 0,0,0,1,0, 0,10'd0,32'h0);
    addV(0,0,8'h00,0, 0,0,0,1,0, 0,10'd0,32'h0);
    addV(0,0,8'h00,1, 1,0,1,0,0, 0,10'd0,32'h0);
    // Zero-length image goes straight to done.
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 0,0,0,1,0, 0,10'd0,32'h0);
    addV(0,0,8'h00,0, 0,0,0,1,0, 0,10'd0,32'h0);
    addV(0,0,8'h00,1, 1,0,1,0,0, 0,10'd0,32'h0);
    // Header 1025 is one word too many.
    addV(0,1,8'h01,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h04,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 0,0,1,0,1, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 0,0,1,0,1, 0,10'd0,32'h0);
    addV(0,0,8'h00,1, 1,0,1,0,0, 0,10'd0,32'h0);
    // Header 0x01000000: low bits are zero but the full count is oversize.
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h01,0, 0,0,1,0,1, 0,10'd0,32'h0);
    addV(0,0,8'h00,1, 1,0,1,0,0, 0,10'd0,32'h0);
    // Header exactly 1024 is accepted; restart inside the image is ignored.
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h04,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h00,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h11,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h22,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h33,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h44,0, 1,1,1,0,0, 1,10'd0,32'h44332211);
    addV(0,0,8'h00,1, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h55,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h66,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h77,0, 1,0,1,0,0, 0,10'd0,32'h0);
    addV(0,1,8'h88,0, 1,1,1,0,0, 1,10'd1,32'h88776655);
    addV(1,0,8'h00,0, 1,0,1,0,0, 1,10'd0,32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].rstrt);
      checkVector(i, vecs[i]);
    end

    // One word with 3-cycle gaps between bytes: single write, nothing spurious.
    pulseReset();
    writeLog.delete();
    sendByte(8'h01, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    sendByte(8'hef, 3); sendByte(8'hbe, 3); sendByte(8'had, 3); sendByte(8'hde, 3);
    checkOutput("gap.writes", 32'(writeLog.size()), 32'd1);
    if (writeLog.size() >= 1) begin
      checkOutput("gap.addr", 32'(writeLog[0].addr), 32'd0);
      checkOutput("gap.data", writeLog[0].data, 32'hDEADBEEF);
    end
    checkOutput("gap.done", 32'(done), 32'd1);
    checkOutput("gap.core_reset", 32'(core_reset), 32'd0);

    // Reset after 6 of 8 data bytes, then a fresh one-word image.
    pulseReset();
    writeLog.delete();
    sendByte(8'h02, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    sendByte(8'h11, 0); sendByte(8'h22, 0); sendByte(8'h33, 0); sendByte(8'h44, 0);
    sendByte(8'h55, 0); sendByte(8'h66, 0);
    pulseReset();
    checkOutput("abort.core_reset", 32'(core_reset), 32'd1);
    checkOutput("abort.in_ready", 32'(in_ready), 32'd1);
    sendByte(8'h01, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    sendByte(8'hef, 0); sendByte(8'hbe, 0); sendByte(8'had, 0); sendByte(8'hde, 0);
    idle(3);
    checkOutput("abort.writes", 32'(writeLog.size()), 32'd2);
    if (writeLog.size() == 2) begin
      checkOutput("abort.w0.addr", 32'(writeLog[0].addr), 32'd0);
      checkOutput("abort.w0.data", writeLog[0].data, 32'h44332211);
      checkOutput("abort.w1.addr", 32'(writeLog[1].addr), 32'd0);
      checkOutput("abort.w1.data", writeLog[1].data, 32'hDEADBEEF);
    end
    checkOutput("abort.done", 32'(done), 32'd1);
    checkOutput("abort.core_reset", 32'(core_reset), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the word-address width, with MEM_WORDS <= 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning a byte is offered on in_data.
REQ-006 SHALL have port in_data, input, 8, the byte stream carrying the program image.
REQ-007 SHALL have port in_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 SHALL have port restart, input, 1, a single-cycle request to begin a new load from DONE or ERR.
REQ-009 SHALL have port mem_we, output, 1, the write strobe to the core instruction/data memory.
REQ-010 SHALL have port mem_addr, output, ADDR_W, the word address of the write.
REQ-011 SHALL have port mem_wdata, output, 32, the word being written.
REQ-012 SHALL have port core_reset, output, 1, which holds riscv_core in reset while high.
REQ-013 SHALL have port done, output, 1, high while the image is loaded and the core is running.
REQ-014 SHALL have port error, output, 1, high after an oversize length header.

Function
REQ-015 SHALL accept a byte only on a cycle with in_valid && in_ready.
REQ-016 SHALL implement states LEN, DATA, DONE and ERR.
REQ-017 SHALL drive in_ready high in LEN and DATA, and low in DONE and ERR.
REQ-018 SHALL read the frame as a 4-byte little-endian word-count header (LEN), followed by count x 4 bytes of little-endian words (DATA).
REQ-019 SHALL assemble bytes in order byte0 = bits[7:0] through byte3 = bits[31:24], using a 2-bit byte counter that wraps 3 -> 0.
REQ-020 SHALL make the LEN -> DATA transition on the 4th header byte when 0 < count <= MEM_WORDS.
REQ-021 SHALL go LEN -> DONE on the 4th header byte when count == 0.
REQ-022 SHALL go LEN -> ERR on the 4th header byte when count > MEM_WORDS, compared in full 32 bits.
REQ-023 SHALL, in DATA, pulse mem_we for exactly one cycle, registered, in the cycle after the 4th byte of each word is accepted.
REQ-024 SHALL present mem_addr as the word index from 0 and mem_wdata as the assembled word during the mem_we cycle.
REQ-025 SHALL increment the word index after each write.
REQ-026 SHALL go DATA -> DONE on the cycle the final write's mem_we is high.
REQ-027 SHALL drop core_reset in that same cycle.
REQ-028 SHALL sustain back-to-back bytes, one per cycle, with no stall, giving a write every 4 cycles.
REQ-029 SHALL insert no bubble after the last header byte; byte0 of word 0 SHALL be accepted the next cycle.
REQ-030 SHALL keep the partial word and byte counter unchanged across gaps where in_valid is low.
REQ-031 SHALL drive core_reset high in LEN, DATA and ERR, and low only in DONE.
REQ-032 SHALL make done == (state == DONE) and error == (state == ERR).
REQ-033 SHALL, on restart in DONE or ERR, move to LEN next cycle, raise core_reset, clear the counters, and clear done and error.
REQ-034 SHALL ignore restart in LEN or DATA.
REQ-035 SHALL hold mem_we low outside DATA; a mid-word restart is not possible because restart is ignored in DATA.

Reset
REQ-036 SHALL, on reset, go to state LEN with byte counter 0, word index 0 and the assembled word 0.
REQ-037 SHALL give these output values during and after reset: core_reset=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, in_ready=1.
REQ-038 SHALL, on reset asserted mid-DATA, abandon the frame with no further mem_we and restart from the header.
REQ-039 SHALL have reset take priority over restart and over byte acceptance in the same cycle.

Structure
REQ-040 SHALL place the state encodings and HDR_BYTES=4 in a shared package prog_loader_pkg.
REQ-041 SHALL implement byte assembly (the byte counter, the shift into the 32-bit word, and word_valid) in one sub-module, byte_packer, instantiated in prog_loader.
REQ-042 SHALL connect mem_we, mem_addr and mem_wdata to the riscv_core memory write port, and core_reset to the riscv_core reset input.

Verification
REQ-043 SHALL check: header 02 00 00 00 followed by 13 05 a0 00 93 05 10 00 -> writes [0]=0x00A00513 and [1]=0x00100593, each with mem_we for 1 cycle, then done=1 and core_reset=0 in the final-write cycle.
REQ-044 SHALL check: header 00 00 00 00 -> no mem_we, done=1 on the cycle after the 4th byte, and in_ready=0.
REQ-045 SHALL check: header 01 04 00 00 (1025) with MEM_WORDS=1024 -> error=1, core_reset=1, in_ready=0, no mem_we; then restart -> LEN with error=0.
REQ-046 SHALL check: one word sent as bytes with 3-cycle in_valid gaps -> the same single write as the gapless case, and no spurious mem_we.
REQ-047 SHALL check: reset pulsed after 6 of 8 data bytes, then a fresh 1-word frame of 0xDEADBEEF -> write [0]=0xDEADBEEF only, and word 1 of the aborted frame is never written.
REQ-048 SHALL check: after done, in_valid held high with data -> no bytes accepted, and core_reset stays 0 until restart.
